// File: rtl/operand_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : operand_debouncer
//  Purpose  : Debounces an 8-bit raw switch vector into two registered 4-bit
//             operands. The switches are first brought into the clock domain
//             by a two-flop synchronizer. A new value is accepted only after
//             the synchronized vector has held for STABLE_CYCLES consecutive
//             cycles. Any bounce during settling restarts the count.
//
//  Ports    : clock    in   1  system clock (rising edge)
//             reset    in   1  synchronous, active-high reset
//             sw       in   8  raw asynchronous switches; [3:0]=A, [7:4]=B
//             A        out  4  debounced operand A (registered)
//             B        out  4  debounced operand B (registered)
//             busy     out  1  high while a candidate value is settling
//             changed  out  1  one-cycle pulse when {B,A} takes a new value
//
//  Parameter: STABLE_CYCLES  settle length in cycles, legal range 2..65535
//
//  Build    : define OPERAND_DEBOUNCE_PULSE_EN to enable the changed pulse.
//             Without it, changed is tied low and its register is not built.
//
//  Revision : 1.0  initial release
// ============================================================================
module operand_debouncer #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] sw,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       busy,
    output logic       changed
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter only has to reach STABLE_CYCLES-1, so clog2(STABLE_CYCLES)
    // bits are enough. With STABLE_CYCLES >= 2 the width is always >= 1.
    localparam int                 c_CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [7:0]         r_s1;       // synchronizer stage 1 (may be metastable)
    logic [7:0]         r_s2;       // synchronizer stage 2, only stage used
    logic [7:0]         r_cand;     // value currently being qualified
    logic [c_CNT_W-1:0] r_cnt;      // consecutive cycles r_s2 has matched r_cand
    logic [7:0]         r_ops;      // accepted operands, {B, A}
    state_t             r_state;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [7:0]         w_cand_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]         w_ops_nxt;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_STABLE;
            r_cand  <= 8'h00;
            r_cnt   <= '0;
            r_ops   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ops   <= w_ops_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_ops_nxt   = r_ops;

        case (r_state)
            ST_STABLE: begin
                // A difference from the accepted value starts a new settle
                // window with the synchronized vector as the candidate.
                if (r_s2 != r_ops) begin
                    w_cand_nxt  = r_s2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (r_s2 != r_cand) begin
                    // Bounce: follow the new value and start counting again.
                    // A bounce back to the accepted value is qualified like
                    // any other, and its acceptance leaves {B,A} unchanged.
                    w_cand_nxt = r_s2;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    // Both nibbles are loaded from one register in one edge,
                    // so A and B can never update separately.
                    w_ops_nxt   = r_cand;
                    w_state_nxt = ST_STABLE;
                end else begin
                    // Saturates at c_CNT_MAX via the branch above; never wraps.
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign A    = r_ops[3:0];
    assign B    = r_ops[7:4];

    // Pure decode of the state register: no combinational path from sw.
    assign busy = (r_state == ST_SETTLE);

`ifdef OPERAND_DEBOUNCE_PULSE_EN
    // r_ops only changes on an acceptance edge, so a difference between its
    // next and current value marks exactly an acceptance of a new value.
    logic r_changed;
    logic w_changed_nxt;

    assign w_changed_nxt = (w_ops_nxt != r_ops);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_changed_nxt;
        end
    end

    assign changed = r_changed;
`else
    assign changed = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_debouncer
//  Purpose  : Directed self-checking bench for operand_debouncer with
//             STABLE_CYCLES = 4 (acceptance 7 edges after a sw change).
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_debouncer;

    localparam int c_STABLE = 4;

`ifdef OPERAND_DEBOUNCE_PULSE_EN
    localparam bit c_PULSE_EN = 1'b1;
`else
    localparam bit c_PULSE_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] sw;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       changed;

    int n_checks;
    int n_pass;

    operand_debouncer #(
        .STABLE_CYCLES(c_STABLE)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .sw     (sw),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .changed(changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        sw    = 8'h00;
        tick();
        tick();
        n_checks++;
        if ({B, A, busy, changed} !== {8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_asserted: got {B,A}=%h busy=%b changed=%b, want 00 0 0",
                     {B, A}, busy, changed);
        end else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({B, A, busy, changed} !== {8'h00, 1'b0, 1'b0}) begin
                $display("FAIL reset_hold[%0d]: got {B,A}=%h busy=%b changed=%b, want 00 0 0",
                         i, {B, A}, busy, changed);
            end else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    // 00 -> 3A clean step. Edge e after the change:
    //   busy high after edges 3..6, {B,A}=3A from edge 7, changed only at 7.
    task automatic test_clean_step();
        logic [7:0] exp_ops;
        logic       exp_busy;
        logic       exp_chg;
        sw = 8'h3A;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_ops  = (e >= 7) ? 8'h3A : 8'h00;
            exp_busy = (e >= 3) && (e <= 6);
            exp_chg  = c_PULSE_EN && (e == 7);
            n_checks++;
            if ({B, A} !== exp_ops) begin
                $display("FAIL clean_ops[e%0d]: got %h, want %h", e, {B, A}, exp_ops);
            end else n_pass++;
            n_checks++;
            if (busy !== exp_busy) begin
                $display("FAIL clean_busy[e%0d]: got %b, want %b", e, busy, exp_busy);
            end else n_pass++;
            n_checks++;
            if (changed !== exp_chg) begin
                $display("FAIL clean_changed[e%0d]: got %b, want %b", e, changed, exp_chg);
            end else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Toggle 3B/3A every 2 cycles for 20 cycles (ends on 3A), then hold 3B.
    task automatic test_toggle();
        logic [7:0] exp_ops;
        logic       exp_chg;
        for (int i = 0; i < 20; i++) begin
            sw = (((i / 2) % 2) == 0) ? 8'h3B : 8'h3A;
            tick();
            n_checks++;
            if ({{B, A}, changed} !== {8'h3A, 1'b0}) begin
                $display("FAIL toggle_hold[%0d]: got {B,A}=%h changed=%b, want 3A 0",
                         i, {B, A}, changed);
            end else n_pass++;
        end
        sw = 8'h3B;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_ops = (e >= 7) ? 8'h3B : 8'h3A;
            exp_chg = c_PULSE_EN && (e == 7);
            n_checks++;
            if ({B, A} !== exp_ops) begin
                $display("FAIL toggle_final_ops[e%0d]: got %h, want %h", e, {B, A}, exp_ops);
            end else n_pass++;
            n_checks++;
            if (changed !== exp_chg) begin
                $display("FAIL toggle_final_changed[e%0d]: got %b, want %b", e, changed, exp_chg);
            end else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    // From stable 3A, glitch to 00 for 3 cycles then return.
    task automatic test_glitch();
        bit saw_busy;
        sw = 8'h3A;
        for (int e = 1; e <= 8; e++) tick();
        n_checks++;
        if ({{B, A}, busy} !== {8'h3A, 1'b0}) begin
            $display("FAIL glitch_setup: got {B,A}=%h busy=%b, want 3A 0", {B, A}, busy);
        end else n_pass++;

        saw_busy = 1'b0;
        sw = 8'h00;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) sw = 8'h3A;
            tick();
            if (busy) saw_busy = 1'b1;
            n_checks++;
            if ({{B, A}, changed} !== {8'h3A, 1'b0}) begin
                $display("FAIL glitch_hold[%0d]: got {B,A}=%h changed=%b, want 3A 0",
                         i, {B, A}, changed);
            end else n_pass++;
        end
        n_checks++;
        if (saw_busy !== 1'b1) begin
            $display("FAIL glitch_busy_seen: got %b, want 1", saw_busy);
        end else n_pass++;
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL glitch_busy_end: got %b, want 0", busy);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    // Reset while settling toward FF, then full re-qualification after release.
    task automatic test_reset_mid_settle();
        logic [7:0] exp_ops;
        logic       exp_chg;
        sw = 8'hFF;
        for (int e = 1; e <= 4; e++) tick();
        n_checks++;
        if ({{B, A}, busy} !== {8'h3A, 1'b1}) begin
            $display("FAIL midreset_settling: got {B,A}=%h busy=%b, want 3A 1", {B, A}, busy);
        end else n_pass++;

        reset = 1'b1;
        tick();
        n_checks++;
        if ({B, A, busy, changed} !== {8'h00, 1'b0, 1'b0}) begin
            $display("FAIL midreset_cleared: got {B,A}=%h busy=%b changed=%b, want 00 0 0",
                     {B, A}, busy, changed);
        end else n_pass++;
        reset = 1'b0;

        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_ops = (e >= 7) ? 8'hFF : 8'h00;
            exp_chg = c_PULSE_EN && (e == 7);
            n_checks++;
            if ({B, A} !== exp_ops) begin
                $display("FAIL midreset_ops[e%0d]: got %h, want %h", e, {B, A}, exp_ops);
            end else n_pass++;
            n_checks++;
            if (changed !== exp_chg) begin
                $display("FAIL midreset_changed[e%0d]: got %b, want %b", e, changed, exp_chg);
            end else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        sw       = 8'h00;

        test_reset();
        test_clean_step();
        test_toggle();
        test_glitch();
        test_reset_mid_settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
